// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 parallel video capture, RGB444 assembly and decimation into a frame buffer
//
// Samples the camera bus (pclk/vsync/href/d) in the clk domain, assembles
// RGB444 pixels from byte pairs, keeps one pixel in every 2^C_DEC_LOG2 columns
// and rows, and writes kept pixels to sequential frame buffer addresses.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   cfg_done        camera configuration complete; low holds/returns to idle
//   ov7670_pclk     camera pixel clock (asynchronous to clk)
//   ov7670_vsync    vertical sync, high between frames
//   ov7670_href     line valid
//   ov7670_d        camera data byte
//   fb_we           frame buffer write strobe, one cycle per stored pixel
//   fb_addr         frame buffer write address
//   fb_data         stored pixel {R,G,B}, 4 bits each
//   frame_done      one-cycle pulse at the end of each captured frame
module ov7670_capture #(
  parameter int C_DEC_LOG2 = 3,
  parameter int C_COLS_IN  = 640,
  parameter int C_ROWS_IN  = 480,
  parameter int C_COLS_OUT = C_COLS_IN >> C_DEC_LOG2,
  parameter int C_ROWS_OUT = C_ROWS_IN >> C_DEC_LOG2,
  parameter int C_AW       = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_done,
  input  logic            ov7670_pclk,
  input  logic            ov7670_vsync,
  input  logic            ov7670_href,
  input  logic [7:0]      ov7670_d,
  output logic            fb_we,
  output logic [C_AW-1:0] fb_addr,
  output logic [11:0]     fb_data,
  output logic            frame_done
);

  localparam logic [1:0] S_WAIT_CFG   = 2'd0;
  localparam logic [1:0] S_WAIT_FRAME = 2'd1;
  localparam logic [1:0] S_CAPTURE    = 2'd2;

  localparam logic [9:0]      COLS_LIM  = 10'(C_COLS_IN);
  localparam logic [8:0]      ROWS_LIM  = 9'(C_ROWS_IN);
  localparam logic [C_AW-1:0] ADDR_LAST = C_AW'(C_COLS_OUT * C_ROWS_OUT - 1);

  // All camera signals share the same synchronizer depth so d/href stay
  // aligned with the pclk edge that qualifies them.
  logic       pclk_s1, pclk_s2, pclk_s3;
  logic       vsync_s1, vsync_s2, vsync_s3;
  logic       href_s1, href_s2, href_s3;
  logic [7:0] d_s1, d_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_s1  <= 1'b0; pclk_s2  <= 1'b0; pclk_s3  <= 1'b0;
      vsync_s1 <= 1'b0; vsync_s2 <= 1'b0; vsync_s3 <= 1'b0;
      href_s1  <= 1'b0; href_s2  <= 1'b0; href_s3  <= 1'b0;
      d_s1     <= 8'd0; d_s2     <= 8'd0;
    end else begin
      pclk_s1  <= ov7670_pclk;  pclk_s2  <= pclk_s1;  pclk_s3  <= pclk_s2;
      vsync_s1 <= ov7670_vsync; vsync_s2 <= vsync_s1; vsync_s3 <= vsync_s2;
      href_s1  <= ov7670_href;  href_s2  <= href_s1;  href_s3  <= href_s2;
      d_s1     <= ov7670_d;     d_s2     <= d_s1;
    end
  end

  logic pclk_rise, vsync_rise, vsync_fall, href_rise, href_fall, byte_stb;
  assign pclk_rise  = pclk_s2 & ~pclk_s3;
  assign vsync_rise = vsync_s2 & ~vsync_s3;
  assign vsync_fall = ~vsync_s2 & vsync_s3;
  assign href_rise  = href_s2 & ~href_s3;
  assign href_fall  = ~href_s2 & href_s3;
  assign byte_stb   = pclk_rise & href_s2;

  logic [1:0]      state;
  logic            phase;
  logic [3:0]      r_nib;
  logic [9:0]      col;
  logic [8:0]      row;
  logic            pix_v, pix_keep;
  logic [11:0]     pix_data;
  logic [C_AW-1:0] addr_cnt;
  logic            full;
  logic            done_pend;

  // A line start may coincide with its first byte; treat that byte as phase 0, col 0.
  logic       phase_eff;
  logic [9:0] col_eff;
  assign phase_eff = href_rise ? 1'b0 : phase;
  assign col_eff   = href_rise ? 10'd0 : col;

  logic we_next;
  assign we_next = pix_v & pix_keep & ~full & cfg_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_WAIT_CFG;
      phase      <= 1'b0;
      r_nib      <= 4'd0;
      col        <= 10'd0;
      row        <= 9'd0;
      pix_v      <= 1'b0;
      pix_keep   <= 1'b0;
      pix_data   <= 12'd0;
      addr_cnt   <= '0;
      full       <= 1'b0;
      done_pend  <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= 12'd0;
      frame_done <= 1'b0;
    end else begin
      pix_v      <= 1'b0;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;

      if (href_rise) begin
        phase <= 1'b0;
        col   <= 10'd0;
      end
      if (byte_stb) begin
        if (!phase_eff) begin
          r_nib <= d_s2[3:0];
          phase <= 1'b1;
        end else begin
          phase    <= 1'b0;
          pix_data <= {r_nib, d_s2};
          pix_v    <= 1'b1;
          pix_keep <= (state == S_CAPTURE) &&
                      (col_eff[C_DEC_LOG2-1:0] == '0) && (row[C_DEC_LOG2-1:0] == '0) &&
                      (col_eff < COLS_LIM) && (row < ROWS_LIM);
          // Saturate so oversize lines can never wrap back onto kept columns.
          if (col_eff != 10'h3ff) col <= col_eff + 10'd1;
        end
      end
      if (state == S_CAPTURE && href_fall && row != 9'h1ff) row <= row + 9'd1;

      // Output register; the address sticks at the last slot once it is used.
      if (we_next) begin
        fb_we   <= 1'b1;
        fb_addr <= addr_cnt;
        fb_data <= pix_data;
        if (addr_cnt == ADDR_LAST) full <= 1'b1;
        else addr_cnt <= addr_cnt + 1'b1;
      end
      // End-of-frame pulse yields to a pending write so the two never overlap.
      if (done_pend && !we_next && cfg_done) begin
        frame_done <= 1'b1;
        done_pend  <= 1'b0;
      end

      if (!cfg_done) begin
        state     <= S_WAIT_CFG;
        done_pend <= 1'b0;
        pix_v     <= 1'b0;
      end else begin
        case (state)
          S_WAIT_CFG: state <= S_WAIT_FRAME;
          S_WAIT_FRAME: begin
            if (vsync_fall) begin
              state    <= S_CAPTURE;
              col      <= 10'd0;
              row      <= 9'd0;
              phase    <= 1'b0;
              addr_cnt <= '0;
              full     <= 1'b0;
            end
          end
          S_CAPTURE: begin
            if (vsync_rise) begin
              state     <= S_WAIT_FRAME;
              done_pend <= 1'b1;
            end
          end
          default: state <= S_WAIT_CFG;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - randomized camera stream bench for ov7670_capture
module tb_ov7670_capture;

  localparam int DEC  = 2;
  localparam int CI   = 16;
  localparam int RI   = 16;
  localparam int CO   = CI >> DEC;
  localparam int RO   = RI >> DEC;
  localparam int AW   = 13;
  localparam int NOUT = CO * RO;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_done = 1'b0;
  logic          pclk = 1'b0;
  logic          vsync = 1'b1;
  logic          href = 1'b0;
  logic [7:0]    d = 8'd0;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [11:0]   fb_data;
  logic          frame_done;

  int checks = 0;
  int errors = 0;
  int got_addr[$];
  int got_data[$];
  int exp_data[$];
  int done_cnt = 0;
  int viol = 0;
  bit prev_we = 1'b0;

  ov7670_capture #(
    .C_DEC_LOG2(DEC), .C_COLS_IN(CI), .C_ROWS_IN(RI),
    .C_COLS_OUT(CO), .C_ROWS_OUT(RO), .C_AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_done(cfg_done),
    .ov7670_pclk(pclk), .ov7670_vsync(vsync), .ov7670_href(href), .ov7670_d(d),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  initial begin
    #3;
    forever #20 pclk = ~pclk;
  end

  // Collect writes and protocol violations away from the active clock edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (fb_we) begin
        got_addr.push_back(int'(fb_addr));
        got_data.push_back(int'(fb_data));
        if (prev_we) viol++;
        if (frame_done) viol++;
      end
      if (frame_done) done_cnt++;
      prev_we = fb_we;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Camera model: drives one frame; the expected stored pixels are every
  // 2^DEC-th pixel of every 2^DEC-th line inside the nominal frame, in order.
  task automatic send_frame(input int cols, input int lines, input bit expect_cap, input bit fixed);
    int kept;
    logic [7:0] b0, b1;
    kept = 0;
    exp_data.delete();
    vsync = 1'b1;
    repeat (8) @(negedge pclk);
    vsync = 1'b0;
    repeat (6) @(negedge pclk);
    for (int r = 0; r < lines; r++) begin
      href = 1'b1;
      for (int c = 0; c < cols; c++) begin
        b0 = fixed ? 8'h0A : 8'($urandom);
        b1 = fixed ? 8'h5C : 8'($urandom);
        d = b0;
        @(negedge pclk);
        d = b1;
        @(negedge pclk);
        if (expect_cap && (r % (1 << DEC) == 0) && (c % (1 << DEC) == 0) &&
            r < RI && c < CI && kept < NOUT) begin
          exp_data.push_back(int'({b0[3:0], b1}));
          kept++;
        end
      end
      href = 1'b0;
      d = 8'($urandom);
      repeat (3) @(negedge pclk);
    end
    vsync = 1'b1;
    repeat (10) @(negedge pclk);
  endtask

  task automatic check_frame(input string tag, input int exp_done);
    int n;
    chk({tag, " write_count"}, got_addr.size(), exp_data.size());
    n = (got_addr.size() < exp_data.size()) ? got_addr.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), got_addr[i], i);
      chk($sformatf("%s data[%0d]", tag, i), got_data[i], exp_data[i]);
    end
    chk({tag, " frame_done_count"}, done_cnt, exp_done);
    chk({tag, " protocol"}, viol, 0);
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    viol = 0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset fb_we", int'(fb_we), 0);
    chk("reset fb_addr", int'(fb_addr), 0);
    chk("reset fb_data", int'(fb_data), 0);
    chk("reset frame_done", int'(frame_done), 0);
    rst = 1'b0;

    send_frame(CI, RI, 1'b0, 1'b0);
    check_frame("cfg_low", 0);

    fork
      send_frame(CI, RI, 1'b0, 1'b0);
      begin
        repeat (600) @(negedge clk);
        cfg_done = 1'b1;
      end
    join
    check_frame("cfg_mid", 0);

    send_frame(CI, RI, 1'b1, 1'b0);
    check_frame("full_rand", 1);

    send_frame(CI, RI, 1'b1, 1'b1);
    check_frame("fixed_a5c", 1);

    send_frame(CI + 6, RI + 5, 1'b1, 1'b0);
    chk("oversize last_addr", (got_addr.size() > 0) ? got_addr[got_addr.size()-1] : -1, NOUT - 1);
    check_frame("oversize", 1);

    send_frame(CI, 6, 1'b1, 1'b0);
    check_frame("aborted", 1);

    send_frame(CI, RI, 1'b1, 1'b0);
    check_frame("after_abort", 1);

    fork
      send_frame(CI, RI, 1'b0, 1'b0);
      begin
        repeat (700) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst fb_we", int'(fb_we), 0);
        chk("midrst fb_addr", int'(fb_addr), 0);
        chk("midrst fb_data", int'(fb_data), 0);
        chk("midrst frame_done", int'(frame_done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        got_addr.delete();
        got_data.delete();
        done_cnt = 0;
        viol = 0;
      end
    join
    check_frame("rst_mid", 0);

    send_frame(CI, RI, 1'b1, 1'b0);
    check_frame("post_rst", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Pixel capture stage directly downstream of the OV7670 configuration controller. Once the camera has been configured, it samples the camera's parallel video bus (PCLK, VSYNC, HREF, D[7:0]) in the FPGA clock domain and assembles RGB444 pixels from byte pairs. It decimates the 640x480 stream to 80x60 and writes each kept pixel into an external 4800-word frame buffer.

## Interface
- C_DEC_LOG2, 3, log2 of decimation factor in both axes (8).
- C_COLS_IN, 640, camera pixels per line.
- C_ROWS_IN, 480, camera lines per frame.
- C_COLS_OUT, 80, stored pixels per line (C_COLS_IN >> C_DEC_LOG2).
- C_ROWS_OUT, 60, stored lines per frame.
- C_AW, 13, frame buffer address width.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  FPGA system clock.
- rst  in  1  asynchronous reset, active high.
- cfg_done  in  1  configuration complete (`done` of the configuration controller).
- ov7670_pclk  in  1  camera pixel clock, asynchronous to clk.
- ov7670_vsync  in  1  camera vertical sync; high between frames.
- ov7670_href  in  1  camera line valid.
- ov7670_d  in  8  camera data byte.
- fb_we  out  1  frame buffer write strobe, one clk cycle per pixel.
- fb_addr  out  C_AW  write address, 0..C_COLS_OUT*C_ROWS_OUT-1.
- fb_data  out  12  pixel {R[3:0],G[3:0],B[3:0]}.
- frame_done  out  1  one-cycle pulse at the end of each captured frame.

## Operation
- Synchronizers: pclk, vsync, href and d each pass through the same 2-FF synchronizer, so all four stay aligned. A third register on synchronized pclk, vsync and href provides edge detection.
- A pclk rising edge is detected as `pclk_s2 & ~pclk_s3`. All sampling uses the synchronized d/href values at that edge.
- FSM states: WAIT_CFG, WAIT_FRAME, CAPTURE.
  - WAIT_CFG: stays here while cfg_done=0. Goes to WAIT_FRAME when cfg_done=1.
  - WAIT_FRAME: waits for a vsync falling edge, then clears the col, row, byte-phase and address counters and goes to CAPTURE.
  - CAPTURE: on a vsync rising edge, pulses frame_done and goes to WAIT_FRAME.
  - cfg_done=0 in any state returns the FSM to WAIT_CFG immediately. No pulse and no further writes occur.
- Byte assembly, on each pclk edge with href=1:
  - Phase 0 latches d[3:0] as R.
  - Phase 1 forms the pixel {R, d[7:0]}.
  - The phase toggles on every byte and is forced to 0 on every href rising edge.
- Counters:
  - col (10 bits) increments per assembled pixel and clears on href rising.
  - row (9 bits) increments on each href falling edge seen in CAPTURE.
- Keep rule: a pixel is written iff col[C_DEC_LOG2-1:0]==0, row[C_DEC_LOG2-1:0]==0, col<C_COLS_IN, row<C_ROWS_IN and the state is CAPTURE.
- Address: a running counter, incremented after each write and cleared at frame start. It is never advanced past C_COLS_OUT*C_ROWS_OUT-1; writes that would exceed it are suppressed.
- Oversize lines or frames (extra pixels or lines) are ignored with no wrap.
- A short frame (vsync rising early) still pulses frame_done. The next frame restarts at address 0.

## Timing
- Reset values: fb_we=0, fb_addr=0, fb_data=0, frame_done=0, FSM=WAIT_CFG, all counters 0, synchronizers 0.
- Requirement: f_clk >= 4*f_pclk (100 MHz clk, <=25 MHz pclk).
- Latency: fb_we asserts 4 clk cycles after the pclk rising edge carrying the second byte on the pin (2 synchronizer + 1 edge + 1 output register).
- fb_addr and fb_data are registered and valid in the same cycle as fb_we, and hold until the next write.
- fb_we is never high on two consecutive cycles.
- frame_done asserts 4 clk cycles after the vsync rising edge on the pin.
- A write and frame_done never coincide. A vsync rising edge in the same cycle as a pixel edge: the pixel is written first, frame_done follows one cycle later.
- Reset mid-frame: outputs clear asynchronously. After reset release, capture resumes only at the next vsync falling edge that occurs with cfg_done=1.

## Test plan
- Reset check: assert rst while the camera model is streaming -> all outputs 0 during reset, and no fb_we until after the next vsync falling edge.
- Full frame (cfg_done=1, 640x480, pixel bytes 0x0A,0x5C) -> exactly 4800 fb_we, addresses 0..4799 in order, fb_data=0xA5C, then one frame_done pulse.
- Gating: cfg_done=0 for a whole frame -> zero writes and no frame_done. cfg_done raised mid-frame -> capture starts at the following frame, first address 0.
- Line content: pixel index p encoded in the bytes -> the stored pixels of line 0 are indices 0, 8, ..., 632, at addresses 0..79.
- Oversize frame (700 px x 500 lines) -> still 4800 writes, last address 4799, no write with fb_addr>4799.
- Aborted frame: vsync rises after 100 lines -> frame_done pulses after 13 stored rows (1040 writes); the next full frame starts at address 0.
